glyph_blitter: RTL and testbench

GLYPH_BLITTER -- requirements
Module: glyph_blitter

---
 rtl/lcd_pkg.sv | 20 ++
 rtl/glyph_scan_ctr.sv | 49 ++++
 rtl/glyph_blitter.sv | 130 +++++++++++++
 tb/tb_glyph_blitter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: blitter FSM encoding, default glyph/framebuffer geometry
// and a counter-width helper used by the scan logic.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_FLUSH = 2'd2
  } blit_state_t;

  localparam int LCD_FONT_ROWS   = 16;
  localparam int LCD_FB_STRIDE   = 40;
  localparam int LCD_DIGIT_PITCH = 2;

  // A counter over n values needs at least one bit even when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glyph_scan_ctr.sv
// Digit/row scan counter: row is the inner loop, digit the outer loop; wraps to
// (0,0) after the last cell and flags that last cell combinationally.
module glyph_scan_ctr
  import lcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int FONT_ROWS  = LCD_FONT_ROWS,
  parameter int DW         = cnt_width(NUM_DIGITS),
  parameter int RW         = cnt_width(FONT_ROWS)
) (
  input  logic          CLOCK_50,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [DW-1:0] d,
  output logic [RW-1:0] r,
  output logic          last
);

  localparam logic [DW-1:0] D_MAX = DW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] R_MAX = RW'(FONT_ROWS - 1);

  logic [DW-1:0] d_reg;
  logic [RW-1:0] r_reg;
  logic          row_last;

  assign row_last = (r_reg == R_MAX);
  assign last     = row_last && (d_reg == D_MAX);
  assign d        = d_reg;
  assign r        = r_reg;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      d_reg <= '0;
      r_reg <= '0;
    end else if (clr) begin
      d_reg <= '0;
      r_reg <= '0;
    end else if (adv) begin
      if (row_last) begin
        r_reg <= '0;
        d_reg <= last ? '0 : d_reg + DW'(1);
      end else begin
        r_reg <= r_reg + RW'(1);
      end
    end
  end

endmodule

// File: rtl/glyph_blitter.sv
// Copies font ROM rows for a row of glyph cells into a byte framebuffer, redrawing
// whenever the glyph codes change or a redraw is requested.
module glyph_blitter
  import lcd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int FONT_ROWS   = LCD_FONT_ROWS,
  parameter int FB_STRIDE   = LCD_FB_STRIDE,
  parameter int DIGIT_PITCH = LCD_DIGIT_PITCH,
  parameter int FB_BASE     = 0
) (
  input  logic                    CLOCK_50,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] glyph_in,
  input  logic                    redraw,
  output logic [31:0]             font_addr,
  input  logic [7:0]              font_data,
  output logic                    fb_we,
  output logic [31:0]             fb_waddr,
  output logic [7:0]              fb_wdata,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = cnt_width(NUM_DIGITS);
  localparam int RW = cnt_width(FONT_ROWS);

  blit_state_t             state_reg, state_next;
  logic [7*NUM_DIGITS-1:0] snap_reg;
  logic                    snap_valid_reg;
  logic                    pend_reg;
  logic                    wr_valid_reg;
  logic [31:0]             waddr_reg;
  logic [7:0]              wdata_hold_reg;
  logic                    done_reg, done_next;

  logic                    start, load, clr, adv, rd_active;
  logic [DW-1:0]           d;
  logic [RW-1:0]           r;
  logic                    last;
  logic [6:0]              code;
  logic [31:0]             wr_addr_next;

  glyph_scan_ctr #(
    .NUM_DIGITS(NUM_DIGITS),
    .FONT_ROWS (FONT_ROWS),
    .DW        (DW),
    .RW        (RW)
  ) u_scan (
    .CLOCK_50(CLOCK_50),
    .rst_n   (rst_n),
    .clr     (clr),
    .adv     (adv),
    .d       (d),
    .r       (r),
    .last    (last)
  );

  assign start     = redraw || pend_reg || !snap_valid_reg || (glyph_in != snap_reg);
  assign rd_active = (state_reg == ST_DRAW);

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    clr        = 1'b0;
    adv        = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_DRAW;
          load       = 1'b1;
          clr        = 1'b1;
        end
      end
      ST_DRAW: begin
        adv = 1'b1;
        if (last) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Read address is combinational so the ROM sees it in the same cycle the
  // counter holds (d,r); the matching write address is registered alongside.
  assign code         = snap_reg[7*int'(d) +: 7];
  assign font_addr    = 32'(code) * 32'(FONT_ROWS) + 32'(r);
  assign wr_addr_next = 32'(FB_BASE) + 32'(d) * 32'(DIGIT_PITCH) + 32'(r) * 32'(FB_STRIDE);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      snap_reg       <= '0;
      snap_valid_reg <= 1'b0;
      pend_reg       <= 1'b0;
      wr_valid_reg   <= 1'b0;
      waddr_reg      <= '0;
      wdata_hold_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      done_reg     <= done_next;
      wr_valid_reg <= rd_active;
      if (load) begin
        snap_reg       <= glyph_in;
        snap_valid_reg <= 1'b1;
      end
      if (state_reg != ST_IDLE) begin
        if (redraw) pend_reg <= 1'b1;
      end else if (load) begin
        pend_reg <= 1'b0;
      end
      if (rd_active) waddr_reg <= wr_addr_next;
      if (wr_valid_reg) wdata_hold_reg <= font_data;
    end
  end

  // ROM data lands during the write cycle, so it goes straight out; the hold
  // register keeps the last written byte visible between passes.
  assign fb_we    = wr_valid_reg;
  assign fb_waddr = waddr_reg;
  assign fb_wdata = wr_valid_reg ? font_data : wdata_hold_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_glyph_blitter.sv
// Directed bench for glyph_blitter: font ROM model returns addr[7:0]; writes are
// logged at the falling edge and checked against hand-computed tables.
module tb_glyph_blitter;

  localparam logic [27:0] G1 = 28'h21FC281; // d0=0x01 d1=0x05 d2=0x7F d3=0x10
  localparam logic [27:0] G2 = 28'h000000A; // d0=0x0A
  localparam logic [27:0] G3 = 28'h0000003; // d0=0x03
  localparam logic [27:0] G4 = 28'h0000009; // d0=0x09

  logic        CLOCK_50 = 1'b0;
  logic        rst_n    = 1'b0;
  logic        redraw   = 1'b0;
  logic [27:0] glyph_in = '0;
  logic [31:0] font_addr, fb_waddr;
  logic [7:0]  font_data = 8'd0;
  logic [7:0]  fb_wdata;
  logic        fb_we, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          done_cnt = 0;

  typedef struct {
    logic [27:0] glyph;
    int          idx;
    logic [31:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vt[11];

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) font_data <= font_addr[7:0];

  always @(negedge CLOCK_50) begin
    if (fb_we) begin
      log_addr.push_back(fb_waddr);
      log_data.push_back(fb_wdata);
    end
    if (done) done_cnt++;
  end

  glyph_blitter #(
    .NUM_DIGITS (4),
    .FONT_ROWS  (16),
    .FB_STRIDE  (40),
    .DIGIT_PITCH(2),
    .FB_BASE    (0)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .glyph_in (glyph_in),
    .redraw   (redraw),
    .font_addr(font_addr),
    .font_data(font_data),
    .fb_we    (fb_we),
    .fb_waddr (fb_waddr),
    .fb_wdata (fb_wdata),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Advances negedge by negedge until done is seen; cyc is the edge count taken.
  task automatic wait_done(input string name, input int limit, output int cyc);
    int got;
    got = 0;
    cyc = 0;
    while (cyc < limit && got == 0) begin
      @(negedge CLOCK_50);
      cyc++;
      if (done) got = 1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic count_idle(input string name, input int n);
    int we_n, busy_n;
    we_n = 0;
    busy_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      if (fb_we) we_n++;
      if (busy) busy_n++;
    end
    check({name, "_we"}, 32'(we_n), 32'd0);
    check({name, "_busy"}, 32'(busy_n), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, base, base2, d0, g1_base, nw;
    logic [27:0] cur;

    vt[0]  = '{G1, 16, 32'd2,   8'd80};
    vt[1]  = '{G1, 31, 32'd602, 8'd95};
    vt[2]  = '{G1, 0,  32'd0,   8'd16};
    vt[3]  = '{G1, 7,  32'd280, 8'd23};
    vt[4]  = '{G1, 32, 32'd4,   8'd240};
    vt[5]  = '{G1, 47, 32'd604, 8'd255};
    vt[6]  = '{G1, 51, 32'd126, 8'd3};
    vt[7]  = '{G1, 63, 32'd606, 8'd15};
    vt[8]  = '{G2, 0,  32'd0,   8'd160};
    vt[9]  = '{G2, 9,  32'd360, 8'd169};
    vt[10] = '{G2, 20, 32'd162, 8'd4};

    // Reset state
    tick(3);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_font_addr", font_addr, 32'd0);
    check("rst_fb_waddr", fb_waddr, 32'd0);
    check("rst_fb_wdata", 32'(fb_wdata), 32'd0);

    // First pass after release with glyph_in = 0
    rst_n = 1'b1;
    d0 = done_cnt;
    tick(1);
    check("first_busy", 32'(busy), 32'd1);
    wait_done("first_done", 200, c);
    check("first_done_cycle", 32'(c + 1), 32'd66);
    check("first_nwrites", 32'(log_addr.size()), 32'd64);
    check("first_addr0", log_addr[0], 32'd0);
    check("first_addr63", log_addr[63], 32'd606);
    check("first_data5", 32'(log_data[5]), 32'd5);
    check("first_data63", 32'(log_data[63]), 32'd15);
    tick(1);
    check("first_busy_after", 32'(busy), 32'd0);
    check("first_done_pulses", 32'(done_cnt - d0), 32'd1);
    $display("pass0 glyph=%h writes=%0d", glyph_in, log_addr.size());

    // Table vectors: one pass per distinct glyph word
    cur = 28'd0;
    base = 0;
    g1_base = 0;
    for (int i = 0; i < 11; i++) begin
      if (vt[i].glyph != cur) begin
        tick(2);
        cur = vt[i].glyph;
        base = log_addr.size();
        if (cur == G1) g1_base = base;
        glyph_in = cur;
        wait_done("tbl_done", 200, c);
        check("tbl_nwrites", 32'(log_addr.size() - base), 32'd64);
      end
      check("tbl_addr", log_addr[base + vt[i].idx], vt[i].addr);
      check("tbl_data", 32'(log_data[base + vt[i].idx]), 32'(vt[i].data));
      $display("vec %0d glyph=%h idx=%0d addr=%0d data=%0d", i, vt[i].glyph, vt[i].idx,
               log_addr[base + vt[i].idx], log_data[base + vt[i].idx]);
    end

    // Digit 1 = 0x05 in G1: row r lands at 2+40r with data 80+r
    for (int rr = 0; rr < 16; rr++) begin
      check("d1_addr", log_addr[g1_base + 16 + rr], 32'(2 + 40 * rr));
      check("d1_data", 32'(log_data[g1_base + 16 + rr]), 32'(80 + rr));
    end

    // No change, no redraw: stays idle
    count_idle("idle200", 200);

    // Glyph change 10 cycles into a pass: old codes now, new pass right after done
    base = log_addr.size();
    glyph_in = G3;
    tick(10);
    glyph_in = G4;
    wait_done("chg_done1", 200, c);
    check("chg_nwrites1", 32'(log_addr.size() - base), 32'd64);
    check("chg_old_data0", 32'(log_data[base]), 32'd48);
    check("chg_old_data15", 32'(log_data[base + 15]), 32'd63);
    tick(1);
    check("chg_restart_busy", 32'(busy), 32'd1);
    base2 = base + 64;
    wait_done("chg_done2", 200, c);
    check("chg_new_data0", 32'(log_data[base2]), 32'd144);
    check("chg_new_data63", 32'(log_data[base2 + 63]), 32'd15);
    check("chg_nwrites2", 32'(log_addr.size() - base2), 32'd64);
    count_idle("chg_after", 30);
    $display("glyph change passes writes=%0d", log_addr.size() - base);

    // Two redraw pulses in one pass -> exactly one extra pass
    base = log_addr.size();
    d0 = done_cnt;
    redraw = 1'b1;
    tick(1);
    redraw = 1'b0;
    tick(5);
    redraw = 1'b1;
    tick(1);
    redraw = 1'b0;
    tick(10);
    redraw = 1'b1;
    tick(1);
    redraw = 1'b0;
    wait_done("rd_done1", 200, c);
    tick(1);
    check("rd_restart_busy", 32'(busy), 32'd1);
    wait_done("rd_done2", 200, c);
    count_idle("rd_after", 100);
    check("rd_nwrites", 32'(log_addr.size() - base), 32'd128);
    check("rd_done_pulses", 32'(done_cnt - d0), 32'd2);
    $display("redraw passes writes=%0d", log_addr.size() - base);

    // Reset at write 30 aborts the pass; release gives a full fresh pass
    redraw = 1'b1;
    tick(1);
    redraw = 1'b0;
    nw = 0;
    c = 0;
    while (nw < 30 && c < 200) begin
      @(negedge CLOCK_50);
      c++;
      if (fb_we) nw++;
    end
    check("mid_reach30", 32'(nw), 32'd30);
    rst_n = 1'b0;
    #1;
    check("mid_fb_we", 32'(fb_we), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_fb_waddr", fb_waddr, 32'd0);
    count_idle("mid_in_reset", 3);
    base = log_addr.size();
    rst_n = 1'b1;
    tick(1);
    check("rel_busy", 32'(busy), 32'd1);
    wait_done("rel_done", 200, c);
    check("rel_done_cycle", 32'(c + 1), 32'd66);
    check("rel_nwrites", 32'(log_addr.size() - base), 32'd64);
    check("rel_addr0", log_addr[base], 32'd0);
    check("rel_data0", 32'(log_data[base]), 32'd144);
    check("rel_addr63", log_addr[base + 63], 32'd606);
    $display("post-reset pass writes=%0d", log_addr.size() - base);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
